// File: rtl/load_store_unit.sv
// Memory-access stage engine: issues one RAM access per load/store and formats
// the returned word (big-endian, byte offset 0 is bits 31:24) for the pipeline.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_address,
    input  logic [31:0] req_store_data,
    input  logic [31:0] req_rt_value,
    output logic        stall,
    output logic        result_valid,
    output logic [31:0] result,
    output logic        address_error,
    output logic        bus_error,
    output logic        ram_request,
    output logic        ram_write,
    output logic [31:0] ram_address,
    output logic [3:0]  ram_select,
    output logic [31:0] ram_write_data,
    input  logic        ram_ready,
    input  logic [31:0] ram_read_data
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam logic [3:0] OP_LB  = 4'h0;
    localparam logic [3:0] OP_LBU = 4'h1;
    localparam logic [3:0] OP_LH  = 4'h2;
    localparam logic [3:0] OP_LHU = 4'h3;
    localparam logic [3:0] OP_LW  = 4'h4;
    localparam logic [3:0] OP_LWL = 4'h5;
    localparam logic [3:0] OP_LWR = 4'h6;
    localparam logic [3:0] OP_SB  = 4'h8;
    localparam logic [3:0] OP_SH  = 4'h9;
    localparam logic [3:0] OP_SW  = 4'hA;

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    state;
    logic [3:0]    op_q;
    logic [1:0]    off_q;
    logic [31:0]   rt_q;
    logic [CW-1:0] count;

    logic          legal;
    logic          aligned;
    logic          start;
    logic [3:0]    sel_d;
    logic [31:0]   wdata_d;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    logic [31:0]   lwl_mask;
    logic [31:0]   lwr_mask;
    logic [31:0]   load_data;

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        legal   = 1'b1;
        aligned = 1'b1;
        case (req_op)
            OP_LB, OP_LBU, OP_LWL, OP_LWR, OP_SB: aligned = 1'b1;
            OP_LH, OP_LHU, OP_SH:                 aligned = ~req_address[0];
            OP_LW, OP_SW:                         aligned = (req_address[1:0] == 2'b00);
            default:                              legal   = 1'b0;
        endcase
    end

    assign start = (state == IDLE) && req_valid && legal;
    // Gated by reset so the pipeline is released the moment reset asserts.
    assign stall = reset && (start || (state == ACCESS));

    always_comb begin
        sel_d   = 4'b1111;
        wdata_d = req_store_data;
        case (req_op)
            OP_SB: begin
                sel_d   = 4'b1000 >> req_address[1:0];
                wdata_d = {4{req_store_data[7:0]}};
            end
            OP_SH: begin
                sel_d   = req_address[1] ? 4'b0011 : 4'b1100;
                wdata_d = {2{req_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Load formatting works on the captured offset and the word returned this cycle.
    always_comb begin
        case (off_q)
            2'd0:    byte_v = ram_read_data[31:24];
            2'd1:    byte_v = ram_read_data[23:16];
            2'd2:    byte_v = ram_read_data[15:8];
            default: byte_v = ram_read_data[7:0];
        endcase
        half_v = off_q[1] ? ram_read_data[15:0] : ram_read_data[31:16];
        case (off_q)
            2'd0:    begin lwl_mask = 32'h0000_0000; lwr_mask = 32'h0000_00FF; end
            2'd1:    begin lwl_mask = 32'h0000_00FF; lwr_mask = 32'h0000_FFFF; end
            2'd2:    begin lwl_mask = 32'h0000_FFFF; lwr_mask = 32'h00FF_FFFF; end
            default: begin lwl_mask = 32'h00FF_FFFF; lwr_mask = 32'hFFFF_FFFF; end
        endcase
        case (op_q)
            OP_LB:   load_data = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  load_data = {24'h0, byte_v};
            OP_LH:   load_data = {{16{half_v[15]}}, half_v};
            OP_LHU:  load_data = {16'h0, half_v};
            OP_LW:   load_data = ram_read_data;
            OP_LWL:  load_data = (ram_read_data << {off_q, 3'b000}) | (rt_q & lwl_mask);
            OP_LWR:  load_data = (ram_read_data >> {~off_q, 3'b000}) | (rt_q & ~lwr_mask);
            default: load_data = 32'h0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            op_q           <= 4'h0;
            off_q          <= 2'b00;
            rt_q           <= 32'h0;
            count          <= '0;
            result_valid   <= 1'b0;
            result         <= 32'h0;
            address_error  <= 1'b0;
            bus_error      <= 1'b0;
            ram_request    <= 1'b0;
            ram_write      <= 1'b0;
            ram_address    <= 32'h0;
            ram_select     <= 4'h0;
            ram_write_data <= 32'h0;
        end else begin
            result_valid  <= 1'b0;
            address_error <= 1'b0;
            bus_error     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && aligned) begin
                        op_q           <= req_op;
                        off_q          <= req_address[1:0];
                        rt_q           <= req_rt_value;
                        count          <= '0;
                        ram_request    <= 1'b1;
                        ram_write      <= req_op[3];
                        ram_address    <= {req_address[31:2], 2'b00};
                        ram_select     <= sel_d;
                        ram_write_data <= wdata_d;
                        state          <= ACCESS;
                    end else if (start) begin
                        address_error <= 1'b1;
                        state         <= DONE;
                    end
                end
                ACCESS: begin
                    if (ram_ready) begin
                        result       <= load_data;
                        result_valid <= 1'b1;
                        ram_request  <= 1'b0;
                        ram_write    <= 1'b0;
                        state        <= DONE;
                    end else if (count == LAST_COUNT) begin
                        bus_error   <= 1'b1;
                        ram_request <= 1'b0;
                        ram_write   <= 1'b0;
                        state       <= DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a one-word RAM model with programmable
// ready latency, hand-computed expected values for each access.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [3:0]  req_op;
    logic [31:0] req_address;
    logic [31:0] req_store_data;
    logic [31:0] req_rt_value;
    logic        stall;
    logic        result_valid;
    logic [31:0] result;
    logic        address_error;
    logic        bus_error;
    logic        ram_request;
    logic        ram_write;
    logic [31:0] ram_address;
    logic [3:0]  ram_select;
    logic [31:0] ram_write_data;
    logic        ram_ready;
    logic [31:0] ram_read_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-access observations filled in by run_access
    int          n_stall, n_acc, rv_cnt, rv_cycle, ae_cnt, be_cnt, req_seen, finished;
    logic [31:0] res_seen, addr_seen, data_seen;
    logic [3:0]  sel_seen;
    logic        write_seen;

    load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_op         (req_op),
        .req_address    (req_address),
        .req_store_data (req_store_data),
        .req_rt_value   (req_rt_value),
        .stall          (stall),
        .result_valid   (result_valid),
        .result         (result),
        .address_error  (address_error),
        .bus_error      (bus_error),
        .ram_request    (ram_request),
        .ram_write      (ram_write),
        .ram_address    (ram_address),
        .ram_select     (ram_select),
        .ram_write_data (ram_write_data),
        .ram_ready      (ram_ready),
        .ram_read_data  (ram_read_data)
    );

    always #5 clock = ~clock;

    assign ram_read_data = (ram_address == 32'h0) ? 32'hAABBCCDD : 32'h1234_5678;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Drive one request and watch it to its DONE cycle; ready rises after 'delay' ACCESS cycles.
    task automatic run_access(input logic [3:0] op, input logic [31:0] addr,
                              input logic [31:0] sd, input logic [31:0] rt, input int delay);
        n_stall = 0; n_acc = 0; rv_cnt = 0; rv_cycle = -1; ae_cnt = 0; be_cnt = 0;
        req_seen = 0; finished = 0; res_seen = 32'h0;
        addr_seen = 32'h0; data_seen = 32'h0; sel_seen = 4'h0; write_seen = 1'b0;
        @(negedge clock);
        req_valid = 1'b1; req_op = op; req_address = addr;
        req_store_data = sd; req_rt_value = rt;
        for (int c = 0; c < 64; c++) begin
            #1;
            if (stall) n_stall++;
            if (ram_request) begin
                req_seen++;
                addr_seen = ram_address; sel_seen = ram_select;
                data_seen = ram_write_data; write_seen = ram_write;
                ram_ready = (n_acc == delay);
                n_acc++;
            end else begin
                ram_ready = 1'b0;
            end
            if (result_valid) begin rv_cnt++; rv_cycle = c; res_seen = result; end
            if (address_error) ae_cnt++;
            if (bus_error) be_cnt++;
            if (!stall && c > 0) begin
                finished = 1;
                req_valid = 1'b0;
                break;
            end
            @(negedge clock);
        end
        req_valid = 1'b0;
        ram_ready = 1'b0;
        check("access_completes", finished, 1);
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_op = 4'h0; req_address = 32'h0;
        req_store_data = 32'h0; req_rt_value = 32'h0; ram_ready = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_stall", stall, 0);
        check("reset_ram_request", ram_request, 0);
        check("reset_result_valid", result_valid, 0);
        check("reset_result", result, 32'h0);
        reset = 1'b1;

        run_access(4'h0, 32'h1, 32'h0, 32'h0, 0);
        check("lb_result", res_seen, 32'hFFFFFFBB);
        check("lb_stall_cycles", n_stall, 2);
        check("lb_valid_cycle", rv_cycle, 2);
        check("lb_valid_count", rv_cnt, 1);
        check("lb_ram_write", write_seen, 0);
        check("lb_ram_select", sel_seen, 4'hF);
        run_access(4'h1, 32'h1, 32'h0, 32'h0, 0);
        check("lbu_result", res_seen, 32'h000000BB);
        run_access(4'h2, 32'h2, 32'h0, 32'h0, 0);
        check("lh_result", res_seen, 32'hFFFFCCDD);
        run_access(4'h3, 32'h0, 32'h0, 32'h0, 0);
        check("lhu_result", res_seen, 32'h0000AABB);
        run_access(4'h4, 32'h0, 32'h0, 32'h0, 0);
        check("lw_result", res_seen, 32'hAABBCCDD);

        run_access(4'h5, 32'h1, 32'h0, 32'h11223344, 0);
        check("lwl1_result", res_seen, 32'hBBCCDD44);
        run_access(4'h6, 32'h1, 32'h0, 32'h11223344, 0);
        check("lwr1_result", res_seen, 32'h1122AABB);
        run_access(4'h5, 32'h0, 32'h0, 32'h11223344, 0);
        check("lwl0_result", res_seen, 32'hAABBCCDD);
        run_access(4'h6, 32'h3, 32'h0, 32'h11223344, 0);
        check("lwr3_result", res_seen, 32'hAABBCCDD);

        run_access(4'h8, 32'h3, 32'h0000_00FF, 32'h0, 0);
        check("sb_select", sel_seen, 4'b0001);
        check("sb_write", write_seen, 1);
        check("sb_data", data_seen, 32'hFFFFFFFF);
        check("sb_address", addr_seen, 32'h0);
        check("sb_result_valid", rv_cnt, 1);
        check("sb_result_zero", res_seen, 32'h0);
        run_access(4'h9, 32'h2, 32'h0000_EEFF, 32'h0, 0);
        check("sh_select", sel_seen, 4'b0011);
        check("sh_data", data_seen, 32'hEEFFEEFF);
        run_access(4'hA, 32'h4, 32'h1357_9BDF, 32'h0, 0);
        check("sw_address", addr_seen, 32'h4);
        check("sw_select", sel_seen, 4'hF);
        check("sw_data", data_seen, 32'h1357_9BDF);

        run_access(4'h2, 32'h1, 32'h0, 32'h0, 0);
        check("lh_mis_addr_err", ae_cnt, 1);
        check("lh_mis_no_request", req_seen, 0);
        check("lh_mis_no_valid", rv_cnt, 0);
        run_access(4'hA, 32'h2, 32'h0, 32'h0, 0);
        check("sw_mis_addr_err", ae_cnt, 1);
        check("sw_mis_no_request", req_seen, 0);
        check("sw_mis_no_valid", rv_cnt, 0);

        run_access(4'h4, 32'h0, 32'h0, 32'h0, 3);
        check("wait3_stall_cycles", n_stall, 5);
        check("wait3_result", res_seen, 32'hAABBCCDD);

        run_access(4'h4, 32'h0, 32'h0, 32'h0, 1000);
        check("timeout_access_cycles", n_acc, 16);
        check("timeout_bus_error", be_cnt, 1);
        check("timeout_no_valid", rv_cnt, 0);
        check("timeout_result_held", result, 32'hAABBCCDD);
        @(negedge clock); #1;
        check("timeout_idle_stall", stall, 0);
        check("timeout_idle_request", ram_request, 0);

        // Reset in the middle of an access
        @(negedge clock);
        req_valid = 1'b1; req_op = 4'h4; req_address = 32'h0;
        @(negedge clock); #1;
        check("midrst_request_before", ram_request, 1);
        reset = 1'b0;
        #1;
        check("midrst_request_drop", ram_request, 0);
        check("midrst_stall_drop", stall, 0);
        rv_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock); #1;
            if (result_valid) rv_cnt++;
        end
        req_valid = 1'b0;
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock); #1;
            if (result_valid) rv_cnt++;
        end
        check("midrst_no_valid", rv_cnt, 0);
        check("midrst_idle_stall", stall, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access-stage engine between the CPU MEM pipeline stage and the data RAM port of the sopc.
- Accepts one load/store per request and drives a ready-gated RAM bus with word address, byte selects and replicated store data.
- Formats returned data for the byte, halfword, word, LWL and LWR loads, and stalls the pipeline while the access is in flight.
- Byte ordering is big-endian: byte offset 0 is bits 31:24.

Parameters:
TIMEOUT_CYCLES, 16, number of ram_request cycles without ram_ready before bus_error is reported (minimum 2)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  MEM stage presents an access; fields are held stable while stall=1
req_op  in  4  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR, 8 SB, 9 SH, A SW; other codes are no-ops
req_address  in  32  byte address
req_store_data  in  32  rt value used for stores
req_rt_value  in  32  old rt value used as merge source for LWL/LWR
stall  out  1  holds the pipeline
result_valid  out  1  one-cycle pulse; result is valid
result  out  32  formatted load data (0 for stores)
address_error  out  1  one-cycle pulse on a misaligned access
bus_error  out  1  one-cycle pulse on a RAM timeout
ram_request  out  1  RAM access strobe (registered)
ram_write  out  1  1 = store
ram_address  out  32  word address: req_address with bits 1:0 forced to 0
ram_select  out  4  byte enables; bit 3 = byte offset 0
ram_write_data  out  32  store data
ram_ready  in  1  RAM completes the access this cycle
ram_read_data  in  32  read word, valid when ram_ready=1

Behaviour:
- Reset (async, active-low): state IDLE; all outputs 0; timeout counter 0. Reset asserted mid-access drops ram_request immediately, and no result is produced.
- States: IDLE, ACCESS, DONE.
- IDLE, req_valid with a legal op:
  - stall=1 combinationally.
  - Alignment rules: LH/LHU/SH require addr[0]=0; LW/SW require addr[1:0]=0; LB/LBU/SB/LWL/LWR are always aligned.
  - Aligned: capture op, offset, rt value and address fields; next state ACCESS; ram_request=1 from the next cycle.
  - Misaligned: next state DONE with address_error=1 and result_valid=0; no RAM access is made.
- IDLE, illegal op or req_valid=0: stall=0; no action.
- ACCESS:
  - ram_request, ram_write, ram_address, ram_select and ram_write_data are held constant; stall=1; counter increments each cycle.
  - When ram_ready=1: register the formatted result; go to DONE; drop ram_request next cycle.
  - When the counter reaches TIMEOUT_CYCLES with ram_ready=0: go to DONE with bus_error=1 and result_valid=0.
  - ram_ready outside ACCESS is ignored.
- DONE:
  - stall=0 for exactly one cycle; result_valid pulses for a completed load or store; result is held until the next completion.
  - req_valid is ignored in DONE; next state is IDLE.
  - Minimum load/store occupancy is 3 cycles (IDLE, ACCESS, DONE) when ram_ready=1 on the first ACCESS cycle.
- Store encoding (k = addr[1:0]):
  - SB: select = 1000>>k; data = {4{byte}}.
  - SH: k=0 gives select 1100, k=2 gives 0011; data = {2{half}}.
  - SW: select 1111.
- Loads: ram_write=0; select 1111.
- Load formatting (W = ram_read_data, k = offset):
  - LB/LBU: byte (3-k) of W, sign-extended or zero-extended.
  - LH/LHU: k=0 takes W[31:16], k=2 takes W[15:0], sign-extended or zero-extended.
  - LW: W.
  - LWL: (W << 8k) | (rt & low-8k-bit mask).
  - LWR: (W >> 8(3-k)) | (rt & ~mask), where the mask covers the low 8(k+1) bits; k=3 returns W.
- Width: all shifts are 32-bit; there is no wrap between words.

Test Plan:
- RAM word @0 = AABBCCDD, ram_ready on the first ACCESS cycle. LB 0x1 → FFFFFFBB; LBU 0x1 → 000000BB. stall high for exactly 2 cycles; result_valid pulses in the 3rd cycle.
- LH 0x2 → FFFFCCDD; LHU 0x0 → 0000AABB; LW 0x0 → AABBCCDD.
- rt = 11223344: LWL 0x1 → BBCCDD44; LWR 0x1 → 1122AABB; LWL 0x0 → AABBCCDD; LWR 0x3 → AABBCCDD.
- SB 0xFF to 0x3 → ram_select 0001, ram_write 1, data FFFFFFFF. SH 0xEEFF to 0x2 → select 0011, data EEFFEEFF. SW to 0x4 → ram_address 00000004, select 1111.
- LH 0x1 or SW 0x2 → address_error pulses; ram_request never asserts; result_valid stays 0. Hold ram_ready low for 3 cycles: stall lasts 5 cycles.
- ram_ready held low with TIMEOUT_CYCLES=16 → bus_error after 16 ACCESS cycles, then return to IDLE. Assert reset during ACCESS → ram_request and stall go to 0 asynchronously, and there is no result_valid.
